// File: rtl/burst_shift_register.sv
// burst_shift_register: parallel-load shift register with rotate/fill modes and an autonomous burst engine.
module burst_shift_register #(
  parameter int WIDTH = 16,
  parameter bit ROTATE = 1'b1,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             serial_in,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] q,
  output logic             out,
  output logic             busy,
  output logic             done
);
  localparam logic [0:0] IDLE = 1'b0, BURST = 1'b1;
  logic [0:0]    state;
  logic [CW-1:0] remaining;
  logic          burst_dir, active_dir;
  logic [WIDTH-1:0] shifted;
  assign busy = (state == BURST);
  assign active_dir = busy ? burst_dir : dir;
  assign out = active_dir ? q[0] : q[WIDTH-1];
  // One shifter serves both single shifts and bursts, steered by the active direction
  assign shifted = active_dir ? {ROTATE ? q[0] : serial_in, q[WIDTH-1:1]}
                              : {q[WIDTH-2:0], ROTATE ? q[WIDTH-1] : serial_in};
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
      state <= IDLE;
      remaining <= '0;
      burst_dir <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q <= data;
        state <= IDLE;
        remaining <= '0;
      end else if (state == BURST) begin
        q <= shifted;
        remaining <= remaining - 1'b1;
        if (remaining == CW'(1)) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end else if (start && count != '0) begin
        state <= BURST;
        remaining <= count;
        burst_dir <= dir;
      end else if (shift_en) begin
        q <= shifted;
      end
    end
  end
endmodule
